fact_job_queue: RTL and testbench

- Request front-end for the factorial core. Accepts `n` values over a valid/ready handshake and buffers them in a small FIFO.
- Dispatches one job at a time to the core's `start`/`n` inputs and captures `fn` on the core's `done` pulse.
- Returns `{n, fn}` pairs over a valid/ready result port, in request order.
- Resolves `n = 0` locally because the core cannot terminate on it. Optionally also resolves overflowing requests locally.

---
 rtl/fact_job_queue.sv | 169 ++++++++++++++++
 tb/tb_fact_job_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_job_queue.sv
// fact_job_queue: request front-end for the factorial core.
// Buffers n operands in a small FIFO and dispatches them one at a time to
// the core. Results come back as {n, fn} pairs in request order. n = 0 is
// answered locally because the core cannot terminate on it.
// Optional feature macro: FACT_OVF_CHECK_EN. When defined, operands above
// N_MAX are answered locally with res_fn = 0 and res_ovf = 1 instead of
// being sent to the core.
//
// state   | meaning
// S_IDLE  | waiting for a queued request; pops the FIFO head when present
// S_ISSUE | one-cycle start pulse to the core with fact_n = job_n
// S_WAIT  | job in flight, fact_n held, waiting for fact_done
// S_OUT   | result held on the result port until res_ready
module fact_job_queue #(
  parameter int N_WIDTH  = 8,
  parameter int FN_WIDTH = 32,
  parameter int DEPTH    = 4,
  parameter int N_MAX    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N_WIDTH-1:0]  req_n,
  output logic                fact_start,
  output logic [N_WIDTH-1:0]  fact_n,
  input  logic                fact_done,
  input  logic [FN_WIDTH-1:0] fact_fn,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N_WIDTH-1:0]  res_n,
  output logic [FN_WIDTH-1:0] res_fn,
  output logic                res_ovf,
  output logic                busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]       DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [N_WIDTH-1:0]   N_MAX_C = N_WIDTH'(N_MAX);

`ifdef FACT_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [N_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                full, empty, push, pop;
  logic [N_WIDTH-1:0]  head_n;
  logic                head_zero, ovf_hit;

  logic [N_WIDTH-1:0]  job_n;
  logic [N_WIDTH-1:0]  fact_n_q;
  logic [N_WIDTH-1:0]  res_n_q;
  logic [FN_WIDTH-1:0] res_fn_q;
  logic                res_ovf_q;

  // FIFO status; ready comes only from registered count, never from a pop
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push      = req_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign head_n    = mem[rd_ptr];
  assign head_zero = (head_n == '0);
  // With the feature compiled out this is constant 0 and the local
  // overflow path disappears.
  assign ovf_hit   = OVF_EN && (head_n > N_MAX_C);

  // FIFO storage write; no reset needed, entries are qualified by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_n;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // FSM next-state logic; fact_done outside S_WAIT is ignored
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (head_zero || ovf_hit) state_nx = S_OUT;
          else                      state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (fact_done) state_nx = S_OUT;
      S_OUT:   if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    fact_start = (state == S_ISSUE);
    res_valid  = (state == S_OUT);
    busy       = (state != S_IDLE) || !empty;
    req_ready  = !full;
  end

  // Job and result registers; loaded on pop (local results) or on done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      job_n     <= '0;
      fact_n_q  <= '0;
      res_n_q   <= '0;
      res_fn_q  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      if (pop) begin
        job_n <= head_n;
        if (head_zero) begin
          res_n_q   <= head_n;
          res_fn_q  <= FN_WIDTH'(1);
          res_ovf_q <= 1'b0;
        end else if (ovf_hit) begin
          res_n_q   <= head_n;
          res_fn_q  <= '0;
          res_ovf_q <= 1'b1;
        end else begin
          fact_n_q <= head_n;
        end
      end
      if ((state == S_WAIT) && fact_done) begin
        res_n_q   <= job_n;
        res_fn_q  <= fact_fn;
        res_ovf_q <= 1'b0;
      end
    end
  end

  assign fact_n  = fact_n_q;
  assign res_n   = res_n_q;
  assign res_fn  = res_fn_q;
  assign res_ovf = res_ovf_q;

endmodule

// File: tb/tb_fact_job_queue.sv
// Self-checking bench for fact_job_queue with a behavioural factorial core
// and a scoreboard of expected {n, fn, ovf} results in request order.
module tb_fact_job_queue;

  localparam int NW = 8;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NW-1:0] req_n = '0;
  logic          fact_start;
  logic [NW-1:0] fact_n;
  logic          fact_done = 1'b0;
  logic [FW-1:0] fact_fn = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [NW-1:0] res_n;
  logic [FW-1:0] res_fn;
  logic          res_ovf;
  logic          busy;

  fact_job_queue #(.N_WIDTH(NW), .FN_WIDTH(FW), .DEPTH(4), .N_MAX(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .fact_start(fact_start), .fact_n(fact_n),
    .fact_done(fact_done), .fact_fn(fact_fn),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_n(res_n), .res_fn(res_fn), .res_ovf(res_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] n;
    logic [FW-1:0] fn;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   starts = 0;
  int   results = 0;

  int            lat = 2;
  bit            stray_done = 1'b0;
  logic          core_busy = 1'b0;
  int            core_cnt = 0;
  logic [NW-1:0] core_n = '0;

  function automatic logic [FW-1:0] ref_fact(logic [NW-1:0] n);
    logic [FW-1:0] p;
    p = 1;
    for (int i = 2; i <= int'(n); i++) p = p * FW'(i);
    return p;
  endfunction

  function automatic exp_t make_exp(logic [NW-1:0] n);
    exp_t e;
    e.n = n;
    e.ovf = 1'b0;
    if (n == 0) e.fn = 1;
`ifdef FACT_OVF_CHECK_EN
    else if (n > 12) begin e.fn = 0; e.ovf = 1'b1; end
`endif
    else e.fn = ref_fact(n);
    return e;
  endfunction

  // Behavioural core: sees start just after the edge, answers lat+1 cycles later
  always @(posedge clk) begin
    #1;
    fact_done = 1'b0;
    if (!rst) begin
      core_busy = 1'b0;
    end else if (stray_done) begin
      fact_done = 1'b1;
      fact_fn   = 32'hDEAD_BEEF;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        fact_done = 1'b1;
        fact_fn   = ref_fact(core_n);
        core_busy = 1'b0;
      end else begin
        core_cnt--;
      end
    end else if (fact_start) begin
      core_busy = 1'b1;
      core_n    = fact_n;
      core_cnt  = lat;
    end
  end

  // Account for handshakes at the current negedge, then advance one cycle
  task automatic step();
    exp_t e;
    if (rst && req_valid && req_ready) sb_q.push_back(make_exp(req_n));
    if (rst && fact_start) begin
      starts++;
      checks++;
      if (res_valid !== 1'b0 || sb_q.size() == 0) begin
        failures++;
        $display("FAIL start_ctx: res_valid=%0b sb_size=%0d, need res_valid=0 and a pending job",
                 res_valid, sb_q.size());
      end else if (fact_n !== sb_q[0].n) begin
        failures++;
        $display("FAIL start_n: fact_n=%0d expected %0d", fact_n, sb_q[0].n);
      end
    end
    if (rst && res_valid && res_ready) begin
      results++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: n=%0d fn=%0d with empty scoreboard", res_n, res_fn);
      end else begin
        e = sb_q.pop_front();
        if (res_n !== e.n || res_fn !== e.fn || res_ovf !== e.ovf) begin
          failures++;
          $display("FAIL result: got n=%0d fn=%0d ovf=%0b expected n=%0d fn=%0d ovf=%0b",
                   res_n, res_fn, res_ovf, e.n, e.fn, e.ovf);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic push_one(input logic [NW-1:0] v);
    req_valid = 1'b1;
    req_n     = v;
    for (int k = 0; k < 200 && !req_ready; k++) step();
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL push_timeout: req_ready=%0b expected 1 for n=%0d", req_ready, v);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_results(input int target);
    for (int k = 0; k < 500 && results < target; k++) step();
    checks++;
    if (results < target) begin
      failures++;
      $display("FAIL result_timeout: results=%0d expected %0d", results, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, fact_start, res_valid, res_ovf, busy} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: {req_ready,fact_start,res_valid,res_ovf,busy}=%b expected 10000",
               {req_ready, fact_start, res_valid, res_ovf, busy});
    end
    checks++;
    if (fact_n !== '0 || res_n !== '0 || res_fn !== '0) begin
      failures++;
      $display("FAIL reset_data: fact_n=%0d res_n=%0d res_fn=%0d expected 0 0 0", fact_n, res_n, res_fn);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    lat = 2;
    push_one(8'd5);
    checks++;
    if (fact_start !== 1'b0) begin
      failures++;
      $display("FAIL single_early_start: fact_start=%0b expected 0 at t+1", fact_start);
    end
    step();
    checks++;
    if (fact_start !== 1'b1 || fact_n !== 8'd5) begin
      failures++;
      $display("FAIL single_start: fact_start=%0b fact_n=%0d expected 1 and 5 at t+2", fact_start, fact_n);
    end
    for (int k = 0; k < 50 && fact_done !== 1'b1; k++) step();
    checks++;
    if (fact_done !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_done: fact_done=%0b res_valid=%0b expected 1 and 0", fact_done, res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_n !== 8'd5 || res_fn !== 32'd120) begin
      failures++;
      $display("FAIL single_result: valid=%0b n=%0d fn=%0d expected 1 5 120", res_valid, res_n, res_fn);
    end
    wait_results(results + 1);
  endtask

  task automatic test_zero();
    int s0;
    s0 = starts;
    res_ready = 1'b1;
    push_one(8'd0);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_early: res_valid=%0b expected 0 at t+1", res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b1 || res_n !== 8'd0 || res_fn !== 32'd1 || res_ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_result: valid=%0b n=%0d fn=%0d ovf=%0b expected 1 0 1 0",
               res_valid, res_n, res_fn, res_ovf);
    end
    wait_results(results + 1);
    checks++;
    if (starts != s0) begin
      failures++;
      $display("FAIL zero_start: starts=%0d expected %0d", starts, s0);
    end
  endtask

  task automatic test_fill_order();
    int r0;
    r0 = results;
    res_ready = 1'b0;
    lat = 2;
    for (int v = 1; v <= 5; v++) push_one(NW'(v));
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fill_full: req_ready=%0b busy=%0b expected 0 1", req_ready, busy);
    end
    req_valid = 1'b1;
    req_n = 8'd6;
    repeat (10) step();
    checks++;
    if (req_ready !== 1'b0 || res_valid !== 1'b1 || res_n !== 8'd1) begin
      failures++;
      $display("FAIL fill_hold: req_ready=%0b res_valid=%0b res_n=%0d expected 0 1 1",
               req_ready, res_valid, res_n);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 100 && !req_ready; k++) step();
    step();
    req_valid = 1'b0;
    wait_results(r0 + 6);
  endtask

  task automatic test_overflow();
    int s0, r0;
    s0 = starts;
    r0 = results;
    res_ready = 1'b1;
    push_one(8'd13);
    push_one(8'd3);
    wait_results(r0 + 2);
    checks++;
`ifdef FACT_OVF_CHECK_EN
    if (starts - s0 != 1) begin
      failures++;
      $display("FAIL ovf_starts: starts=%0d expected 1", starts - s0);
    end
`else
    if (starts - s0 != 2) begin
      failures++;
      $display("FAIL ovf_starts: starts=%0d expected 2", starts - s0);
    end
`endif
  endtask

  task automatic test_reset_mid_job();
    bit bad;
    res_ready = 1'b1;
    lat = 8;
    push_one(8'd7);
    for (int k = 0; k < 20 && fact_start !== 1'b1; k++) step();
    step();
    step();
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL midjob_wait: busy=%0b res_valid=%0b expected 1 0", busy, res_valid);
    end
    rst = 1'b0;
    sb_q.delete();
    step();
    step();
    rst = 1'b1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0 || fact_n !== '0) begin
      failures++;
      $display("FAIL midjob_reset: busy=%0b req_ready=%0b res_valid=%0b fact_n=%0d expected 0 1 0 0",
               busy, req_ready, res_valid, fact_n);
    end
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid !== 1'b0 || fact_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midjob_stray: stray fact_done produced activity, expected none");
    end
    lat = 2;
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] vals [10] = '{8'd3, 8'd0, 8'd7, 8'd1, 8'd12, 8'd2, 8'd0, 8'd5, 8'd9, 8'd4};
    int s0, r0;
    s0 = starts;
    r0 = results;
    res_ready = 1'b1;
    lat = 3;
    for (int i = 0; i < 10; i++) push_one(vals[i]);
    wait_results(r0 + 10);
    checks++;
    if (starts - s0 != 8) begin
      failures++;
      $display("FAIL b2b_starts: starts=%0d expected 8", starts - s0);
    end
    checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: sb_size=%0d busy=%0b expected 0 0", sb_q.size(), busy);
    end
    lat = 2;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_fill_order();
    test_overflow();
    test_reset_mid_job();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
